// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
// Holds the response-owner encoding and the funct3 code used for fetches.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating count of data grants taken while a fetch is waiting.
// limit_hit tells the arbiter to let the fetch through on this cycle.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic ssdClk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int unsigned   CW  = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge ssdClk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && cnt != LIM) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit_hit = (cnt == LIM);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between IF-stage fetch and MEM-stage load/store.
// Data has priority unless fetch has been starved; read data is routed to its issuer.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              ssdClk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    logic   if_want;
    logic   starve_hit;
    owner_t owner_q;
    owner_t owner_d;

    assign if_want = if_req & ~if_flush;

    always_comb begin
        if_ack = 1'b0;
        dm_ack = 1'b0;
        if (!rst) begin
            if (dm_req && !(if_want && starve_hit)) begin
                dm_ack = 1'b1;
            end else if (if_want) begin
                if_ack = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en     = if_ack | dm_ack;
        mem_we     = dm_ack & dm_we;
        mem_addr   = '0;
        mem_funct3 = '0;
        mem_wdata  = '0;
        if (if_ack) begin
            mem_addr   = if_addr;
            mem_funct3 = F3_WORD;
        end else if (dm_ack) begin
            mem_addr   = dm_addr;
            mem_funct3 = dm_funct3;
            mem_wdata  = dm_wdata;
        end
    end

    // Any cycle without a waiting, unflushed fetch restarts the starvation window.
    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .ssdClk    (ssdClk),
        .rst       (rst),
        .inc       (dm_ack & if_want),
        .clr       (if_ack | ~if_want),
        .limit_hit (starve_hit)
    );

    always_ff @(posedge ssdClk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d   = OWN_NONE;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rdata  = '0;
        if (if_ack) begin
            owner_d = OWN_IF;
        end else if (dm_ack && !dm_we) begin
            owner_d = OWN_DM;
        end
        case (owner_q)
            OWN_IF: begin
                if_rdata  = mem_rdata;
                if_rvalid = ~rst & ~if_flush;
            end
            OWN_DM: begin
                dm_rdata  = mem_rdata;
                dm_rvalid = ~rst;
            end
            default: ;
        endcase
    end

    assign stall = ~rst & ((if_want & ~if_ack) | (dm_req & ~dm_ack));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a
// randomized run checked against a pending-request reference model.
module tb_unified_mem_arbiter;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned LIM = 4;

    logic          ssdClk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [2:0]    dm_funct3, mem_funct3;
    logic [DW-1:0] dm_wdata, mem_rdata, mem_wdata, if_rdata, dm_rdata;
    logic          if_ack, if_rvalid, dm_ack, dm_rvalid, mem_en, mem_we, stall;

    int total = 0;
    int bad   = 0;

    // Reference model: which requester has a read response due next cycle, and fetch wait count.
    bit          m_pend_fetch = 1'b0;
    bit          m_pend_load  = 1'b0;
    int unsigned m_starve     = 0;

    logic          e_if_ack, e_dm_ack, e_mem_en, e_mem_we, e_stall, e_if_rvalid, e_dm_rvalid;
    logic [AW-1:0] e_mem_addr;
    logic [2:0]    e_mem_f3;
    logic [DW-1:0] e_mem_wdata, e_if_rdata, e_dm_rdata;

    unified_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .ssdClk     (ssdClk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_ack     (if_ack),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_funct3  (dm_funct3),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stall      (stall)
    );

    always #5 ssdClk = ~ssdClk;

    task automatic model_expect();
        bit want;
        want        = if_req && !if_flush;
        e_dm_ack    = !rst && dm_req && !(want && m_starve >= LIM);
        e_if_ack    = !rst && want && !e_dm_ack;
        e_mem_en    = e_if_ack || e_dm_ack;
        e_mem_we    = e_dm_ack && dm_we;
        e_mem_addr  = e_if_ack ? if_addr : (e_dm_ack ? dm_addr : '0);
        e_mem_f3    = e_if_ack ? 3'b010 : (e_dm_ack ? dm_funct3 : 3'b000);
        e_mem_wdata = e_dm_ack ? dm_wdata : '0;
        e_if_rvalid = !rst && m_pend_fetch && !if_flush;
        e_dm_rvalid = !rst && m_pend_load;
        e_if_rdata  = m_pend_fetch ? mem_rdata : '0;
        e_dm_rdata  = m_pend_load ? mem_rdata : '0;
        e_stall     = !rst && ((want && !e_if_ack) || (dm_req && !e_dm_ack));
    endtask

    task automatic model_advance();
        model_expect();
        if (rst) begin
            m_pend_fetch = 1'b0;
            m_pend_load  = 1'b0;
            m_starve     = 0;
        end else begin
            m_pend_fetch = e_if_ack;
            m_pend_load  = e_dm_ack && !dm_we;
            if (e_if_ack || !if_req || if_flush) m_starve = 0;
            else if (e_dm_ack && m_starve < LIM) m_starve = m_starve + 1;
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge ssdClk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_flush = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_funct3 = '0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = 32'h12345678;
    endtask

    task automatic idle();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset();
        rst = 1; if_req = 1; dm_req = 1; dm_addr = 8'h33;
        #2;
        total++; if ({if_ack, dm_ack, mem_en, mem_we, stall} !== 5'b0) begin
            bad++; $display("FAIL reset_force got=%b want=00000", {if_ack, dm_ack, mem_en, mem_we, stall});
        end
        total++; if ({if_rvalid, dm_rvalid} !== 2'b0) begin
            bad++; $display("FAIL reset_rvalid got=%b want=00", {if_rvalid, dm_rvalid});
        end
        tick(); tick();
        rst = 0; clear_inputs();
        #2;
        total++; if (if_rdata !== '0 || dm_rdata !== '0) begin
            bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", if_rdata, dm_rdata);
        end
        total++; if (mem_addr !== '0 || mem_en !== 1'b0) begin
            bad++; $display("FAIL reset_idle got addr=%h en=%b want 0", mem_addr, mem_en);
        end
        tick();
    endtask

    task automatic test_fetch_only();
        if_req = 1; if_addr = 8'h04;
        #2;
        total++; if ({if_ack, dm_ack, stall, mem_en, mem_we} !== 5'b10010) begin
            bad++; $display("FAIL fetch_grant got=%b want=10010", {if_ack, dm_ack, stall, mem_en, mem_we});
        end
        total++; if (mem_addr !== 8'h04 || mem_funct3 !== 3'b010) begin
            bad++; $display("FAIL fetch_bus got addr=%h f3=%b want 04/010", mem_addr, mem_funct3);
        end
        tick();
        if_req = 0; mem_rdata = 32'h00500093;
        #2;
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || dm_rvalid !== 1'b0) begin
            bad++; $display("FAIL fetch_resp got v=%b d=%h dv=%b want 1/00500093/0", if_rvalid, if_rdata, dm_rvalid);
        end
        tick();
        #1;
        total++; if (if_rvalid !== 1'b0) begin
            bad++; $display("FAIL fetch_resp_once got=%b want=0", if_rvalid);
        end
        idle();
    endtask

    task automatic test_conflict();
        logic [DW-1:0] r;
        if_req = 1; if_addr = 8'h08;
        dm_req = 1; dm_we = 0; dm_funct3 = 3'b100; dm_addr = 8'h40;
        #2;
        total++; if ({dm_ack, if_ack, stall} !== 3'b101) begin
            bad++; $display("FAIL conflict_grant got=%b want=101", {dm_ack, if_ack, stall});
        end
        total++; if (mem_addr !== 8'h40 || mem_funct3 !== 3'b100 || mem_we !== 1'b0) begin
            bad++; $display("FAIL conflict_bus got addr=%h f3=%b we=%b want 40/100/0", mem_addr, mem_funct3, mem_we);
        end
        tick();
        r = $urandom; dm_req = 0; mem_rdata = r;
        #2;
        total++; if (dm_rvalid !== 1'b1 || dm_rdata !== r || if_rvalid !== 1'b0) begin
            bad++; $display("FAIL conflict_resp got v=%b d=%h iv=%b want 1/%h/0", dm_rvalid, dm_rdata, if_rvalid, r);
        end
        total++; if (if_ack !== 1'b1 || mem_addr !== 8'h08) begin
            bad++; $display("FAIL conflict_fetch_after got ack=%b addr=%h want 1/08", if_ack, mem_addr);
        end
        tick();
        idle();
    endtask

    task automatic test_starvation();
        if_req = 1; if_addr = 8'h0c;
        dm_req = 1; dm_we = 1; dm_addr = 8'h80; dm_wdata = 32'hcafef00d;
        for (int i = 0; i < 10; i++) begin
            #2;
            total++; if ({if_ack, dm_ack} !== ((i == 4 || i == 9) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL starve_cycle%0d got if/dm=%b want=%b", i, {if_ack, dm_ack},
                                (i == 4 || i == 9) ? 2'b10 : 2'b01);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        if_req = 1; if_addr = 8'h10;
        #2;
        total++; if (if_ack !== 1'b1) begin
            bad++; $display("FAIL flush_pre_grant got=%b want=1", if_ack);
        end
        tick();
        if_flush = 1; dm_req = 1; dm_we = 1; dm_addr = 8'h20; dm_wdata = 32'h0badf00d;
        #2;
        total++; if ({if_rvalid, if_ack, dm_ack, mem_we, stall} !== 5'b00110) begin
            bad++; $display("FAIL flush_cycle got=%b want=00110", {if_rvalid, if_ack, dm_ack, mem_we, stall});
        end
        tick();
        clear_inputs();
        #2;
        total++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin
            bad++; $display("FAIL flush_after got=%b want=00", {if_rvalid, dm_rvalid});
        end
        tick();
    endtask

    task automatic test_store();
        dm_req = 1; dm_we = 1; dm_addr = 8'h10; dm_wdata = 32'hDEADBEEF; dm_funct3 = 3'b000;
        #2;
        total++; if ({mem_we, mem_en, dm_ack} !== 3'b111 || mem_wdata !== 32'hDEADBEEF ||
                     mem_funct3 !== 3'b000 || mem_addr !== 8'h10) begin
            bad++; $display("FAIL store_bus got we=%b wd=%h f3=%b a=%h want 1/DEADBEEF/000/10",
                            mem_we, mem_wdata, mem_funct3, mem_addr);
        end
        tick();
        clear_inputs(); if_req = 1; if_addr = 8'h14;
        #2;
        total++; if (dm_rvalid !== 1'b0 || if_ack !== 1'b1) begin
            bad++; $display("FAIL store_no_rvalid got dv=%b ia=%b want 0/1", dm_rvalid, if_ack);
        end
        tick();
        if_req = 0; mem_rdata = 32'h00a00113;
        dm_req = 1; dm_we = 1; dm_addr = 8'h18; dm_wdata = 32'h11223344; dm_funct3 = 3'b010;
        #2;
        total++; if ({if_rvalid, dm_ack, mem_we} !== 3'b111 || if_rdata !== 32'h00a00113) begin
            bad++; $display("FAIL store_with_resp got=%b d=%h want 111/00a00113", {if_rvalid, dm_ack, mem_we}, if_rdata);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_read();
        if_req = 1; if_addr = 8'h24;
        dm_req = 1; dm_we = 0; dm_addr = 8'h44; dm_funct3 = 3'b010;
        tick(); tick();
        #2;
        total++; if (dm_ack !== 1'b1) begin
            bad++; $display("FAIL rmr_load_grant got=%b want=1", dm_ack);
        end
        tick();
        rst = 1;
        #2;
        total++; if ({dm_rvalid, mem_en, dm_ack, if_ack, stall} !== 5'b0) begin
            bad++; $display("FAIL rmr_reset got=%b want=00000", {dm_rvalid, mem_en, dm_ack, if_ack, stall});
        end
        tick();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (i == 0) begin
                total++; if (dm_rvalid !== 1'b0) begin
                    bad++; $display("FAIL rmr_discard got=%b want=0", dm_rvalid);
                end
            end
            total++; if ({if_ack, dm_ack} !== ((i == 4) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rmr_starve_cycle%0d got=%b want=%b", i, {if_ack, dm_ack},
                                (i == 4) ? 2'b10 : 2'b01);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            if_req    = ($urandom_range(0, 9) < 8);
            if_flush  = ($urandom_range(0, 9) == 0);
            if_addr   = AW'($urandom);
            dm_req    = ($urandom_range(0, 3) != 0);
            dm_we     = $urandom_range(0, 1) == 1;
            dm_funct3 = 3'($urandom);
            dm_addr   = AW'($urandom);
            dm_wdata  = $urandom;
            mem_rdata = $urandom;
            #2;
            model_expect();
            total++; if ({if_ack, dm_ack, mem_en, mem_we, stall} !== {e_if_ack, e_dm_ack, e_mem_en, e_mem_we, e_stall}) begin
                bad++; $display("FAIL rand_ctrl c=%0d got=%b want=%b", c, {if_ack, dm_ack, mem_en, mem_we, stall},
                                {e_if_ack, e_dm_ack, e_mem_en, e_mem_we, e_stall});
            end
            total++; if ({mem_addr, mem_funct3, mem_wdata} !== {e_mem_addr, e_mem_f3, e_mem_wdata}) begin
                bad++; $display("FAIL rand_bus c=%0d got=%h/%b/%h want=%h/%b/%h", c, mem_addr, mem_funct3, mem_wdata,
                                e_mem_addr, e_mem_f3, e_mem_wdata);
            end
            total++; if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== {e_if_rvalid, e_dm_rvalid, e_if_rdata, e_dm_rdata}) begin
                bad++; $display("FAIL rand_resp c=%0d got=%b%b/%h/%h want=%b%b/%h/%h", c, if_rvalid, dm_rvalid, if_rdata,
                                dm_rdata, e_if_rvalid, e_dm_rvalid, e_if_rdata, e_dm_rdata);
            end
            tick();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick(); tick();
        test_reset();
        test_fetch_only();
        test_conflict();
        test_starvation();
        test_flush();
        test_store();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
